// File: rtl/nand3_stim_pkg.sv
// Shared types and constants for the 3-input NAND stimulus driver.
// State encoding, pattern-mode encoding, LFSR taps and counter width.
package nand3_stim_pkg;

  localparam int CNT_W = 16;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_EXH    = 2'd0,
    MODE_LFSR   = 2'd1,
    MODE_GRAY   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nand3_stim_lfsr.sv
// 8-bit Fibonacci LFSR; load or reset restores the seed, advance steps once.
// One-cycle update, no backpressure.
module nand3_stim_lfsr
  import nand3_stim_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] state
);

  // An all-zero seed would lock the register, so substitute 1
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= SEED_EFF;
    end else if (advance) begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/nand3_stim_driver.sv
// Drives vectors into a 3-input NAND, checks QN after settling, counts toggles/errors.
// Each vector takes SETTLE_CYCLES+2 cycles; START is ignored unless idle.
module nand3_stim_driver
  import nand3_stim_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [15:0]      NUM_VEC,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  input  logic             QN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] TOGGLE_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [15:0]      num_vec_q;
  logic [15:0]      idx_q;
  logic [15:0]      idx_inc;
  logic [3:0]       settle_q;
  logic [2:0]       in_q;
  logic [2:0]       vec;
  logic             prev_qn_q;
  logic             done_q;
  logic [CNT_W-1:0] tog_q;
  logic [CNT_W-1:0] err_q;
  logic             exp_qn;
  logic             start_ok;
  logic             last_vec;
  logic [7:0]       lfsr_state;
  logic             unused_lfsr_hi;

  assign idx_inc  = idx_q + 16'd1;
  assign last_vec = (idx_inc == num_vec_q);
  assign start_ok = (state_q == ST_IDLE) && START;
  assign exp_qn   = ~(&in_q);

  // Stepping between samples means APPLY i sees the i-th LFSR state
  nand3_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (CLK),
    .rst     (RST),
    .load    (start_ok),
    .advance ((state_q == ST_SAMPLE) && !last_vec),
    .state   (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[7:3];

  always_comb begin
    vec = 3'b000;
    case (mode_q)
      MODE_EXH:    vec = idx_q[2:0];
      MODE_LFSR:   vec = lfsr_state[2:0];
      MODE_GRAY:   vec = idx_q[2:0] ^ (idx_q[2:0] >> 1);
      MODE_TOGGLE: vec = idx_q[0] ? 3'b011 : 3'b111;
      default:     vec = 3'b000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (START) state_d = (NUM_VEC == '0) ? ST_FIN : ST_APPLY;
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_vec ? ST_FIN : ST_APPLY;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q    <= MODE_EXH;
      num_vec_q <= '0;
      idx_q     <= '0;
      settle_q  <= '0;
      in_q      <= '0;
      prev_qn_q <= 1'b0;
      done_q    <= 1'b0;
      tog_q     <= '0;
      err_q     <= '0;
    end else begin
      done_q <= (state_q == ST_FIN);
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            mode_q    <= mode_t'(MODE);
            num_vec_q <= NUM_VEC;
            idx_q     <= '0;
            tog_q     <= '0;
            err_q     <= '0;
          end
        end
        ST_APPLY: begin
          in_q     <= vec;
          settle_q <= '0;
        end
        ST_SETTLE: settle_q <= settle_q + 4'd1;
        ST_SAMPLE: begin
          prev_qn_q <= QN;
          idx_q     <= idx_inc;
          if (idx_q != '0 && QN != prev_qn_q) tog_q <= sat_inc(tog_q);
          if (QN != exp_qn) err_q <= sat_inc(err_q);
        end
        default: ;
      endcase
    end
  end

  assign {IN3, IN2, IN1} = in_q;
  assign BUSY       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                      (state_q == ST_SAMPLE);
  assign DONE       = done_q;
  assign TOGGLE_CNT = tog_q;
  assign ERR_CNT    = err_q;

endmodule
